memory_bus_responder: RTL
=========================

Name: memory_bus_responder

Overview:
- Target-side end of the CPU address bus: accepts the muxed 16-bit ADDR plus RD/WR strobes from the core and services each access.
- Decodes ADDR into a RAM region (below IO_BASE) and an IO region (IO_BASE and above).
- Sequences RAM wait states and the IO request/acknowledge handshake, then returns read data with a one-cycle READY pulse.
- BUS_ERR flags an IO timeout or an illegal simultaneous RD and WR.

Parameters:
RAM_WAIT, 1, extra cycles RAM_CE is held beyond the first (0..15)
IO_BASE, 16'hF000, first address of IO region
IO_TIMEOUT, 15, cycles IO_REQ may stay high without IO_ACK before an error is flagged (1..255)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
ADDR  in  16  access address from address bus controller; held stable until READY
DIN  in  16  write data from core; held stable until READY
RD  in  1  read request level; held until READY
WR  in  1  write request level; held until READY
DOUT  out  16  read data to core
READY  out  1  one-cycle completion pulse
BUS_ERR  out  1  error flag; valid only with READY
RAM_CE  out  1  RAM chip enable
RAM_WE  out  1  RAM write enable; qualified by RAM_CE
RAM_ADDR  out  16  latched address
RAM_DIN  out  16  latched write data
RAM_DOUT  in  16  RAM read data, valid while RAM_CE is high
IO_REQ  out  1  IO request level
IO_WE  out  1  IO write, qualified by IO_REQ
IO_ADDR  out  8  latched ADDR[7:0]
IO_WDATA  out  16  latched write data
IO_RDATA  in  16  IO read data, valid with IO_ACK
IO_ACK  in  1  IO completion, single cycle

Behaviour:
- Reset (async, immediate): state IDLE; DOUT=16'h0000; READY, BUS_ERR, RAM_CE, RAM_WE, IO_REQ and IO_WE all 0; RAM_ADDR, RAM_DIN, IO_ADDR and IO_WDATA all 0.
- Reset mid-access: the access is aborted, no READY is issued, and outputs go inactive in the same cycle.
- All outputs are registered.
- States: IDLE, RAM, IO, DONE.
- IDLE, RD&WR both high: go to DONE with error set; no RAM or IO cycle.
- IDLE, RD or WR high: latch ADDR, DIN and direction.
  - ADDR >= IO_BASE (unsigned): go to IO.
  - Otherwise: go to RAM, loading the wait counter with RAM_WAIT.
- IDLE, neither RD nor WR: stay in IDLE.
- RAM: RAM_CE=1 and RAM_WE=latched WR for exactly RAM_WAIT+1 cycles.
  - On the final cycle, a read captures RAM_DOUT into DOUT.
  - Then go to DONE.
- IO: IO_REQ=1, IO_WE=latched WR; the timeout counter increments each cycle.
  - IO_ACK high: a read captures IO_RDATA into DOUT; drop IO_REQ; go to DONE.
  - Counter reaches IO_TIMEOUT with no ACK: drop IO_REQ; set error; a read loads DOUT=16'hFFFF; go to DONE.
  - ACK in the same cycle as timeout: ACK wins, no error.
- DONE: READY=1 and BUS_ERR=error for one cycle; clear error; return to IDLE.
  - The core may present a new request in the cycle after READY; IDLE samples it with no dead cycle required.
- IO_ACK outside the IO state is ignored.
- DOUT changes only on read completion and holds otherwise; writes never alter it.
- Latency, request first seen in IDLE at cycle 0:
  - RAM: RAM_CE high in cycles 1..RAM_WAIT+1; READY in cycle RAM_WAIT+2.
  - IO: IO_REQ high from cycle 1; ACK seen in cycle k gives READY in cycle k+1.
  - Timeout: READY in cycle IO_TIMEOUT+2.
- Wait and timeout counters are width-sized for the parameter maxima; no wrap is possible within a single access.

Test Plan:
- RAM read, RAM_WAIT=1: ADDR=16'h0100, RD=1 at cycle 0, RAM_DOUT=16'hBEEF -> RAM_CE high in cycles 1-2, RAM_WE=0, READY in cycle 3, DOUT=16'hBEEF, BUS_ERR=0.
- RAM write, RAM_WAIT=0: ADDR=16'h0002, DIN=16'h1234, WR=1 -> one cycle of RAM_CE=RAM_WE=1 with RAM_DIN=16'h1234, READY in cycle 2, DOUT unchanged.
- Decode boundary: read ADDR=16'hEFFF -> RAM cycle only; read ADDR=16'hF000 -> IO_REQ with IO_ADDR=8'h00, RAM_CE stays 0.
- IO read: ADDR=16'hF005, IO_ACK with IO_RDATA=16'h00A5 in cycle 3 -> IO_REQ high in cycles 1-3, READY in cycle 4, DOUT=16'h00A5, BUS_ERR=0. ACK coinciding with the timeout cycle -> no error.
- IO timeout: IO_TIMEOUT=15, read ADDR=16'hF010, IO_ACK never asserted -> READY and BUS_ERR in cycle 17, DOUT=16'hFFFF. A late IO_ACK afterwards is ignored.
- RD and WR both high -> READY and BUS_ERR in cycle 1, no RAM_CE or IO_REQ. RESET raised during an IO wait -> IO_REQ drops immediately, no READY, next access completes normally.

Source files
------------

// File: rtl/memory_bus_responder.sv
// memory_bus_responder: target-side bus responder decoding ADDR into RAM/IO regions
// Ports:
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   addr, din, rd, wr            request from the core, held until ready
//   dout, ready, bus_err         read data, one-cycle completion pulse, error flag (valid with ready)
//   ram_ce, ram_we, ram_addr,
//   ram_din, ram_dout            RAM strobes, latched address/write data, RAM read data
//   io_req, io_we, io_addr,
//   io_wdata, io_rdata, io_ack   IO request/acknowledge handshake
module memory_bus_responder #(
   parameter int          RAM_WAIT   = 1,
   parameter logic [15:0] IO_BASE    = 16'hF000,
   parameter int          IO_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [15:0] din,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] dout,
   output logic        ready,
   output logic        bus_err,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_din,
   input  logic [15:0] ram_dout,
   output logic        io_req,
   output logic        io_we,
   output logic [7:0]  io_addr,
   output logic [15:0] io_wdata,
   input  logic [15:0] io_rdata,
   input  logic        io_ack
);
   typedef enum logic [1:0] {IDLE, RAM, IO, DONE} state_t;
   state_t     state;
   // RAM counts down from RAM_WAIT; IO counts up towards IO_TIMEOUT
   logic [7:0] cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dout     <= '0;
         ready    <= 1'b0;
         bus_err  <= 1'b0;
         ram_ce   <= 1'b0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         io_req   <= 1'b0;
         io_we    <= 1'b0;
         io_addr  <= '0;
         io_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd && wr) begin
                  ready   <= 1'b1;
                  bus_err <= 1'b1;
                  state   <= DONE;
               end else if (rd || wr) begin
                  ram_addr <= addr;
                  ram_din  <= din;
                  io_addr  <= addr[7:0];
                  io_wdata <= din;
                  if (addr >= IO_BASE) begin
                     state  <= IO;
                     io_req <= 1'b1;
                     io_we  <= wr;
                     cnt    <= '0;
                  end else begin
                     state  <= RAM;
                     ram_ce <= 1'b1;
                     ram_we <= wr;
                     cnt    <= 8'(RAM_WAIT);
                  end
               end
            end
            RAM: begin
               if (cnt == 8'd0) begin
                  if (!ram_we) dout <= ram_dout;
                  ram_ce <= 1'b0;
                  ram_we <= 1'b0;
                  ready  <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            IO: begin
               // ack is checked first so an ack on the timeout cycle still succeeds
               if (io_ack) begin
                  if (!io_we) dout <= io_rdata;
                  io_req <= 1'b0;
                  io_we  <= 1'b0;
                  ready  <= 1'b1;
                  state  <= DONE;
               end else if (cnt == 8'(IO_TIMEOUT)) begin
                  if (!io_we) dout <= 16'hFFFF;
                  io_req  <= 1'b0;
                  io_we   <= 1'b0;
                  ready   <= 1'b1;
                  bus_err <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               ready   <= 1'b0;
               bus_err <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
